// File: rtl/lc3b_types.sv
// Shared types for the decode/issue stage: default sizing constants,
// scoreboard count type and the default-width ID/EX latch layout.
package lc3b_types;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_NUM_REGS     = 8;
  localparam int DEF_CTRL_WIDTH   = 32;
  localparam int DEF_MAX_INFLIGHT = 3;
  localparam int DEF_RW           = $clog2(DEF_NUM_REGS);
  localparam int DEF_CW           = $clog2(DEF_MAX_INFLIGHT + 1);

  typedef logic [DEF_CW-1:0] sb_count_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] instr;
    logic [DEF_CTRL_WIDTH-1:0] ctrl;
    logic [DEF_DATA_WIDTH-1:0] src1;
    logic [DEF_DATA_WIDTH-1:0] src2;
    logic [DEF_RW-1:0]         dest;
    logic                      writes;
  } id_ex_t;

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register in-flight write counters with source/WAW hazard detection.
// With DECODE_BYPASS_EN a same-cycle writeback clears a last-pending source hazard.
import lc3b_types::*;

module decode_scoreboard #(
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  localparam int RW = $clog2(NUM_REGS),
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc_en,
  input  logic [RW-1:0] inc_dest,
  input  logic          lat_wr,
  input  logic [RW-1:0] lat_dest,
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_dest,
  input  logic [RW-1:0] src1,
  input  logic [RW-1:0] src2,
  input  logic          use_src1,
  input  logic          use_src2,
  input  logic          writes,
  input  logic [RW-1:0] dest,
  output logic          haz_src1,
  output logic          haz_src2,
  output logic          waw_stall,
  output logic          sb_err
);

  localparam logic [CW:0] MAX_CNT = (CW+1)'(MAX_INFLIGHT);

  logic [CW-1:0] pending [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) pending[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_en && inc_dest == RW'(r) && !(wb_valid && wb_dest == RW'(r)))
          pending[r] <= pending[r] + 1'b1;
        else if (!(inc_en && inc_dest == RW'(r)) && wb_valid && wb_dest == RW'(r)
                 && pending[r] != '0)
          pending[r] <= pending[r] - 1'b1;
      end
      if (wb_valid && pending[wb_dest] == '0) sb_err <= 1'b1;
    end
  end

  logic pend1, pend2, lat1, lat2;
  logic [CW:0] waw_cnt;

  always_comb begin
    pend1 = pending[src1] != '0;
    pend2 = pending[src2] != '0;
`ifdef DECODE_BYPASS_EN
    // The writeback retiring the last outstanding write is forwarded by the read port.
    if (wb_valid && wb_dest == src1 && pending[src1] == CW'(1)) pend1 = 1'b0;
    if (wb_valid && wb_dest == src2 && pending[src2] == CW'(1)) pend2 = 1'b0;
`endif
    // The latch entry is not yet counted, so it is checked directly.
    lat1      = lat_wr && lat_dest == src1;
    lat2      = lat_wr && lat_dest == src2;
    haz_src1  = use_src1 && (pend1 || lat1);
    haz_src2  = use_src2 && (pend2 || lat2);
    waw_cnt   = {1'b0, pending[dest]} + {{CW{1'b0}}, (lat_wr && lat_dest == dest)};
    waw_stall = writes && (waw_cnt >= MAX_CNT);
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file, scoreboard hazard stall and ID/EX latch.
// Optional macro DECODE_BYPASS_EN forwards same-cycle writeback data to the read ports.
import lc3b_types::*;

module decode_issue_stage #(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int CTRL_WIDTH   = DEF_CTRL_WIDTH,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [DATA_WIDTH-1:0] id_instr,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic [RW-1:0]         id_src1,
  input  logic [RW-1:0]         id_src2,
  input  logic [RW-1:0]         id_dest,
  input  logic                  id_use_src1,
  input  logic                  id_use_src2,
  input  logic                  id_writes,
  input  logic                  flush,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [DATA_WIDTH-1:0] ex_instr,
  output logic [CTRL_WIDTH-1:0] ex_ctrl,
  output logic [DATA_WIDTH-1:0] ex_src1_data,
  output logic [DATA_WIDTH-1:0] ex_src2_data,
  output logic [RW-1:0]         ex_dest,
  output logic                  ex_writes,
  input  logic                  wb_valid,
  input  logic [RW-1:0]         wb_dest,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  sb_err
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [RW-1:0]         dest;
    logic                  writes;
  } latch_t;

  logic [DATA_WIDTH-1:0] rf [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd1, rd2;
  latch_t lat_p0, lat_p1;
  logic   vld_p1;
  logic   haz_src1, haz_src2, waw_stall, stall, accept;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
    end else if (wb_valid) begin
      rf[wb_dest] <= wb_data;
    end
  end

  always_comb begin
    rd1 = rf[id_src1];
    rd2 = rf[id_src2];
`ifdef DECODE_BYPASS_EN
    if (wb_valid && wb_dest == id_src1) rd1 = wb_data;
    if (wb_valid && wb_dest == id_src2) rd2 = wb_data;
`endif
  end

  decode_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .inc_en    (vld_p1 && ex_ready && lat_p1.writes && !flush),
    .inc_dest  (lat_p1.dest),
    .lat_wr    (vld_p1 && lat_p1.writes),
    .lat_dest  (lat_p1.dest),
    .wb_valid  (wb_valid),
    .wb_dest   (wb_dest),
    .src1      (id_src1),
    .src2      (id_src2),
    .use_src1  (id_use_src1),
    .use_src2  (id_use_src2),
    .writes    (id_writes),
    .dest      (id_dest),
    .haz_src1  (haz_src1),
    .haz_src2  (haz_src2),
    .waw_stall (waw_stall),
    .sb_err    (sb_err)
  );

  assign stall    = haz_src1 || haz_src2 || waw_stall;
  assign id_ready = !flush && !stall && (!vld_p1 || ex_ready);
  assign accept   = id_valid && id_ready;

  always_comb begin
    lat_p0        = '0;
    lat_p0.instr  = id_instr;
    lat_p0.ctrl   = id_ctrl;
    lat_p0.src1   = rd1;
    lat_p0.src2   = rd2;
    lat_p0.dest   = id_dest;
    lat_p0.writes = id_writes;
  end

  // ---- p0 -> p1: ID/EX latch ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      lat_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      lat_p1 <= lat_p0;
    end else if (ex_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_instr     = lat_p1.instr;
  assign ex_ctrl      = lat_p1.ctrl;
  assign ex_src1_data = lat_p1.src1;
  assign ex_src2_data = lat_p1.src2;
  assign ex_dest      = lat_p1.dest;
  assign ex_writes    = lat_p1.writes;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed self-checking bench for decode_issue_stage (MAX_INFLIGHT=2 build);
// expectations follow DECODE_BYPASS_EN when it is defined.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_ready;
  logic [15:0] id_instr;
  logic [31:0] id_ctrl;
  logic [2:0]  id_src1, id_src2, id_dest;
  logic        id_use_src1, id_use_src2, id_writes;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [15:0] ex_instr;
  logic [31:0] ex_ctrl;
  logic [15:0] ex_src1_data, ex_src2_data;
  logic [2:0]  ex_dest;
  logic        ex_writes;
  logic        wb_valid;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic        sb_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_issue_stage #(
    .DATA_WIDTH   (16),
    .NUM_REGS     (8),
    .CTRL_WIDTH   (32),
    .MAX_INFLIGHT (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_ctrl      (id_ctrl),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_dest      (id_dest),
    .id_use_src1  (id_use_src1),
    .id_use_src2  (id_use_src2),
    .id_writes    (id_writes),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_instr     (ex_instr),
    .ex_ctrl      (ex_ctrl),
    .ex_src1_data (ex_src1_data),
    .ex_src2_data (ex_src2_data),
    .ex_dest      (ex_dest),
    .ex_writes    (ex_writes),
    .wb_valid     (wb_valid),
    .wb_dest      (wb_dest),
    .wb_data      (wb_data),
    .sb_err       (sb_err)
  );

  task automatic idle();
    id_valid = 1'b0; id_instr = '0; id_ctrl = '0;
    id_src1 = '0; id_src2 = '0; id_dest = '0;
    id_use_src1 = 1'b0; id_use_src2 = 1'b0; id_writes = 1'b0;
    flush = 1'b0; wb_valid = 1'b0; wb_dest = '0; wb_data = '0;
    ex_ready = 1'b1;
  endtask

  task automatic issue(input logic [15:0] ins, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [2:0] d, input logic u1, input logic u2, input logic w);
    id_valid = 1'b1; id_instr = ins; id_ctrl = {16'hC0DE, ins};
    id_src1 = s1; id_src2 = s2; id_dest = d;
    id_use_src1 = u1; id_use_src2 = u2; id_writes = w;
  endtask

  task automatic wb(input logic [2:0] d, input logic [15:0] v);
    wb_valid = 1'b1; wb_dest = d; wb_data = v;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid: got %0h want 0", ex_valid); end
    checks++; if (ex_instr !== 16'h0) begin errors++; $display("FAIL rst_ex_instr: got %0h want 0", ex_instr); end
    checks++; if (ex_ctrl !== 32'h0) begin errors++; $display("FAIL rst_ex_ctrl: got %0h want 0", ex_ctrl); end
    checks++; if (ex_src1_data !== 16'h0 || ex_src2_data !== 16'h0) begin errors++; $display("FAIL rst_ex_src: got %0h/%0h want 0/0", ex_src1_data, ex_src2_data); end
    checks++; if (ex_dest !== 3'd0 || ex_writes !== 1'b0) begin errors++; $display("FAIL rst_ex_dest: got %0h/%0h want 0/0", ex_dest, ex_writes); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rst_sb_err: got %0h want 0", sb_err); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_id_ready: got %0h want 1", id_ready); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    idle();
    issue(16'h1001, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %0h want 1", id_ready); end
    next_cycle();
    issue(16'h1002, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %0h want 1", id_ready); end
    checks++; if (ex_valid !== 1'b1 || ex_instr !== 16'h1001 || ex_dest !== 3'd1) begin errors++; $display("FAIL b2b_lat1: got v=%0h i=%0h d=%0h want 1/1001/1", ex_valid, ex_instr, ex_dest); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (ex_valid !== 1'b1 || ex_instr !== 16'h1002 || ex_dest !== 3'd2 || ex_writes !== 1'b1) begin errors++; $display("FAIL b2b_lat2: got v=%0h i=%0h d=%0h w=%0h want 1/1002/2/1", ex_valid, ex_instr, ex_dest, ex_writes); end
    next_cycle();
    wb(3'd1, 16'h1111);
    @(negedge clk);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0h want 0", ex_valid); end
    next_cycle();
    wb(3'd2, 16'h2222);
    next_cycle();
    idle();
    issue(16'h2003, 3'd1, 3'd2, 3'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready: got %0h want 1", id_ready); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (ex_src1_data !== 16'h1111 || ex_src2_data !== 16'h2222) begin errors++; $display("FAIL b2b_rd_data: got %0h/%0h want 1111/2222", ex_src1_data, ex_src2_data); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL b2b_sb_err: got %0h want 0", sb_err); end
    next_cycle();
  endtask

  task automatic test_raw();
    idle();
    issue(16'h3003, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL raw_add_ready: got %0h want 1", id_ready); end
    next_cycle();
    issue(16'h4004, 3'd3, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_c%0d: got %0h want 0", c, id_ready); end
      next_cycle();
    end
    wb(3'd3, 16'h3333);
    @(negedge clk);
`ifdef DECODE_BYPASS_EN
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready: got %0h want 1", id_ready); end
    next_cycle();
    idle();
    @(negedge clk);
`else
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_ready: got %0h want 0", id_ready); end
    next_cycle();
    wb_valid = 1'b0;
    @(negedge clk);
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL raw_after_wb_ready: got %0h want 1", id_ready); end
    next_cycle();
    idle();
    @(negedge clk);
`endif
    checks++; if (ex_valid !== 1'b1 || ex_instr !== 16'h4004 || ex_src1_data !== 16'h3333) begin errors++; $display("FAIL raw_issue: got v=%0h i=%0h s1=%0h want 1/4004/3333", ex_valid, ex_instr, ex_src1_data); end
    next_cycle();
  endtask

  task automatic test_waw();
    idle();
    issue(16'h5001, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL waw_w1_ready: got %0h want 1", id_ready); end
    next_cycle();
    issue(16'h5002, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL waw_w2_ready: got %0h want 1", id_ready); end
    next_cycle();
    issue(16'h5003, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL waw_w3_latch_stall: got %0h want 0", id_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (id_ready !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL waw_w3_pend_stall: got r=%0h v=%0h want 0/0", id_ready, ex_valid); end
    next_cycle();
    wb(3'd5, 16'h5555);
    @(negedge clk);
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL waw_wb_cycle: got %0h want 0", id_ready); end
    next_cycle();
    wb_valid = 1'b0;
    @(negedge clk);
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL waw_w3_issue: got %0h want 1", id_ready); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (ex_valid !== 1'b1 || ex_instr !== 16'h5003) begin errors++; $display("FAIL waw_w3_latch: got v=%0h i=%0h want 1/5003", ex_valid, ex_instr); end
    next_cycle();
    wb(3'd5, 16'h5556);
    next_cycle();
    wb(3'd5, 16'h5557);
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL waw_sb_err: got %0h want 0", sb_err); end
    next_cycle();
  endtask

  task automatic test_hold();
    idle();
    issue(16'h6006, 3'd1, 3'd2, 3'd6, 1'b1, 1'b1, 1'b1);
    ex_ready = 1'b0;
    @(negedge clk);
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL hold_accept: got %0h want 1", id_ready); end
    next_cycle();
    issue(16'h7007, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_c%0d: got %0h want 0", c, id_ready); end
      checks++; if (ex_valid !== 1'b1 || ex_instr !== 16'h6006 || ex_ctrl !== 32'hC0DE6006) begin errors++; $display("FAIL hold_instr_c%0d: got v=%0h i=%0h c=%0h want 1/6006/c0de6006", c, ex_valid, ex_instr, ex_ctrl); end
      checks++; if (ex_src1_data !== 16'h1111 || ex_src2_data !== 16'h2222) begin errors++; $display("FAIL hold_src_c%0d: got %0h/%0h want 1111/2222", c, ex_src1_data, ex_src2_data); end
      checks++; if (ex_dest !== 3'd6 || ex_writes !== 1'b1) begin errors++; $display("FAIL hold_dest_c%0d: got %0h/%0h want 6/1", c, ex_dest, ex_writes); end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_flush(input logic rdy);
    idle();
    issue(16'h8004, 3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1);
    ex_ready = 1'b0;
    @(negedge clk);
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush%0d_accept: got %0h want 1", rdy, id_ready); end
    next_cycle();
    issue(16'h9009, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    ex_ready = rdy;
    @(negedge clk);
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flush%0d_ready: got %0h want 0", rdy, id_ready); end
    next_cycle();
    idle();
    issue(16'hA00A, 3'd4, 3'd4, 3'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush%0d_killed: got %0h want 0", rdy, ex_valid); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush%0d_reader_ready: got %0h want 1", rdy, id_ready); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (ex_valid !== 1'b1 || ex_instr !== 16'hA00A || ex_src1_data !== 16'h0) begin errors++; $display("FAIL flush%0d_reader: got v=%0h i=%0h s1=%0h want 1/a00a/0", rdy, ex_valid, ex_instr, ex_src1_data); end
    next_cycle();
  endtask

  task automatic test_sb_err();
    idle();
    wb(3'd6, 16'h6666);
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sberr_legit: got %0h want 0", sb_err); end
    wb(3'd6, 16'h6767);
    next_cycle();
    idle();
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL sberr_sticky_c%0d: got %0h want 1", c, sb_err); end
      next_cycle();
    end
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (sb_err !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL sberr_reset: got e=%0h v=%0h want 0/0", sb_err, ex_valid); end
    issue(16'hB00B, 3'd6, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_rf_ready: got %0h want 1", id_ready); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (ex_src1_data !== 16'h0 || ex_src2_data !== 16'h0) begin errors++; $display("FAIL rst_rf_cleared: got %0h/%0h want 0/0", ex_src1_data, ex_src2_data); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_raw();
    test_waw();
    test_hold();
    test_flush(1'b0);
    test_flush(1'b1);
    test_sb_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
